vga_fb_arbiter: RTL and testbench

Single-port framebuffer memory arbiter between the VGA controller's framebuffer fetch port and the CPU data bus. It sits directly upstream of the VGA controller: it serves that controller's `fb_access`/`fb_address` requests with `fb_ack`/`fb_data`, and interleaves CPU reads and writes to the same 32K x 16 synchronous RAM. Display fetches have priority, and every access follows a fixed three-state sequence.

---
 rtl/vga_pkg.sv | 10 +
 rtl/vga_fb_arbiter.sv | 154 +++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types and sizes for the VGA framebuffer arbiter.
package vga_pkg;

    localparam int FB_ADDR_W = 15;
    localparam int FB_WORDS  = 1 << FB_ADDR_W;

    typedef enum logic [1:0] {IDLE, SERVE, ACK} fb_arb_state_t;
    typedef enum logic {OWNER_VGA, OWNER_CPU} fb_owner_t;

endpackage

// File: rtl/vga_fb_arbiter.sv
// Arbitrates a single-port framebuffer RAM between VGA fetches (priority) and CPU accesses.
// Optional macro VGA_FB_FAIRNESS_EN lets a waiting CPU in after three consecutive VGA grants.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fb_access,
    input  logic [15:0]       fb_address,
    output logic              fb_ack,
    output logic [15:0]       fb_data,
    input  logic              cs,
    input  logic [ADDR_W-1:0] data_m_addr,
    input  logic              data_m_wr_en,
    input  logic [1:0]        data_m_bytesel,
    input  logic [15:0]       data_m_data_in,
    output logic [15:0]       data_m_data_out,
    output logic              data_m_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr_en,
    output logic [1:0]        ram_be,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata
);

    fb_arb_state_t     state_q;
    fb_owner_t         owner_q;
    logic              isWrite_q;
    logic [ADDR_W-1:0] ramAddr_q;
    logic              ramWrEn_q;
    logic [1:0]        ramBe_q;
    logic [15:0]       ramWdata_q;
    logic              fbAck_q;
    logic [15:0]       fbData_q;
    logic              dataMAck_q;
    logic [15:0]       dataMOut_q;

    logic              grantVga;
    logic              grantCpu;

    // The VGA port carries a 16-bit address but only the low ADDR_W bits select a word.
    if (ADDR_W < 16) begin : gFbAddrHigh
        logic unusedFbAddrHigh;
        assign unusedFbAddrHigh = ^fb_address[15:ADDR_W];
    end

`ifdef VGA_FB_FAIRNESS_EN
    logic [1:0] vgaStreak_q;
    logic [1:0] vgaStreak_d;

    // A streak of three VGA grants under a pending CPU request hands the next slot to the CPU.
    always_comb begin
        grantCpu    = cs && (!fb_access || vgaStreak_q == 2'd3);
        grantVga    = fb_access && !grantCpu;
        vgaStreak_d = vgaStreak_q;
        if (state_q == IDLE) begin
            if (grantCpu) begin
                vgaStreak_d = 2'd0;
            end else if (grantVga) begin
                if (!cs) begin
                    vgaStreak_d = 2'd0;
                end else if (vgaStreak_q != 2'd3) begin
                    vgaStreak_d = vgaStreak_q + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vgaStreak_q <= 2'd0;
        end else begin
            vgaStreak_q <= vgaStreak_d;
        end
    end
`else
    always_comb begin
        grantVga = fb_access;
        grantCpu = cs && !fb_access;
    end
`endif

    // RAM strobes are registered on the grant edge so they are stable throughout SERVE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= OWNER_VGA;
            isWrite_q  <= 1'b0;
            ramAddr_q  <= '0;
            ramWrEn_q  <= 1'b0;
            ramBe_q    <= 2'b00;
            ramWdata_q <= 16'h0000;
            fbAck_q    <= 1'b0;
            fbData_q   <= 16'h0000;
            dataMAck_q <= 1'b0;
            dataMOut_q <= 16'h0000;
        end else begin
            fbAck_q    <= 1'b0;
            dataMAck_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grantVga) begin
                        owner_q   <= OWNER_VGA;
                        isWrite_q <= 1'b0;
                        ramAddr_q <= fb_address[ADDR_W-1:0];
                        ramWrEn_q <= 1'b0;
                        ramBe_q   <= 2'b00;
                        state_q   <= SERVE;
                    end else if (grantCpu) begin
                        owner_q    <= OWNER_CPU;
                        isWrite_q  <= data_m_wr_en;
                        ramAddr_q  <= data_m_addr;
                        ramWrEn_q  <= data_m_wr_en;
                        ramBe_q    <= data_m_wr_en ? data_m_bytesel : 2'b00;
                        ramWdata_q <= data_m_data_in;
                        state_q    <= SERVE;
                    end
                end
                SERVE: begin
                    ramWrEn_q <= 1'b0;
                    ramBe_q   <= 2'b00;
                    state_q   <= ACK;
                end
                ACK: begin
                    if (owner_q == OWNER_VGA) begin
                        fbAck_q  <= 1'b1;
                        fbData_q <= ram_rdata;
                    end else begin
                        dataMAck_q <= 1'b1;
                        if (!isWrite_q) begin
                            dataMOut_q <= ram_rdata;
                        end
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign fb_ack          = fbAck_q;
    assign fb_data         = fbData_q;
    assign data_m_ack      = dataMAck_q;
    assign data_m_data_out = dataMOut_q;
    assign ram_addr        = ramAddr_q;
    assign ram_wr_en       = ramWrEn_q;
    assign ram_be          = ramBe_q;
    assign ram_wdata       = ramWdata_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized self-checking bench for vga_fb_arbiter against a transaction-level arbitration model.
// Honours VGA_FB_FAIRNESS_EN when the design is built with it.
module tb_vga_fb_arbiter;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fb_access = 1'b0;
    logic [15:0] fb_address = 16'h0000;
    logic        fb_ack;
    logic [15:0] fb_data;
    logic        cs = 1'b0;
    logic [14:0] data_m_addr = 15'h0000;
    logic        data_m_wr_en = 1'b0;
    logic [1:0]  data_m_bytesel = 2'b00;
    logic [15:0] data_m_data_in = 16'h0000;
    logic [15:0] data_m_data_out;
    logic        data_m_ack;
    logic [14:0] ram_addr;
    logic        ram_wr_en;
    logic [1:0]  ram_be;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    logic [15:0] mem [FB_WORDS];
    logic [15:0] refMem [FB_WORDS];

    int          errors = 0;
    int          checks = 0;

    // Model state: the one outstanding access, its delivery countdown and the data owners hold.
    int          pendOwner = 0;
    int          countdown = 0;
    logic [15:0] pendData = 16'h0000;
    logic        pendWrite = 1'b0;
    logic [15:0] lastFb = 16'h0000;
    logic [15:0] lastCpu = 16'h0000;
    int          streak = 0;
    logic        vgaAckSeen = 1'b0;
    logic        cpuAckSeen = 1'b0;

    always #5 clk = ~clk;

    vga_fb_arbiter #(.ADDR_W(15)) dut (
        .clk            (clk),
        .reset          (reset),
        .fb_access      (fb_access),
        .fb_address     (fb_address),
        .fb_ack         (fb_ack),
        .fb_data        (fb_data),
        .cs             (cs),
        .data_m_addr    (data_m_addr),
        .data_m_wr_en   (data_m_wr_en),
        .data_m_bytesel (data_m_bytesel),
        .data_m_data_in (data_m_data_in),
        .data_m_data_out(data_m_data_out),
        .data_m_ack     (data_m_ack),
        .ram_addr       (ram_addr),
        .ram_wr_en      (ram_wr_en),
        .ram_be         (ram_be),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata)
    );

    // Synchronous single-port RAM with byte enables and one-cycle read latency.
    always @(posedge clk) begin
        if (ram_wr_en) begin
            if (ram_be[0]) mem[ram_addr][7:0]  <= ram_wdata[7:0];
            if (ram_be[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: retire the outstanding access when due and compare every observable output.
    task automatic stepCycle();
        logic expVga;
        logic expCpu;
        @(negedge clk);
        expVga = 1'b0;
        expCpu = 1'b0;
        if (pendOwner != 0) begin
            countdown--;
            if (countdown == 0) begin
                if (pendOwner == 1) begin
                    expVga = 1'b1;
                    lastFb = pendData;
                end else begin
                    expCpu = 1'b1;
                    if (!pendWrite) lastCpu = pendData;
                end
                pendOwner = 0;
            end
        end
        checkOutput("fb_ack", {31'b0, fb_ack}, {31'b0, expVga});
        checkOutput("data_m_ack", {31'b0, data_m_ack}, {31'b0, expCpu});
        checkOutput("fb_data", {16'b0, fb_data}, {16'b0, lastFb});
        checkOutput("data_m_data_out", {16'b0, data_m_data_out}, {16'b0, lastCpu});
        vgaAckSeen = fb_ack;
        cpuAckSeen = data_m_ack;
    endtask

    // When the arbiter is free and something is requesting, decide the grant from the priority rules.
    task automatic modelGrant();
        logic cpuWins;
        if (reset || pendOwner != 0 || !(fb_access || cs)) return;
`ifdef VGA_FB_FAIRNESS_EN
        cpuWins = cs && (!fb_access || streak == 3);
`else
        cpuWins = cs && !fb_access;
`endif
        if (cpuWins) begin
            pendOwner = 2;
            pendWrite = data_m_wr_en;
            if (data_m_wr_en) begin
                if (data_m_bytesel[0]) refMem[data_m_addr][7:0]  = data_m_data_in[7:0];
                if (data_m_bytesel[1]) refMem[data_m_addr][15:8] = data_m_data_in[15:8];
            end else begin
                pendData = refMem[data_m_addr];
            end
            streak = 0;
        end else begin
            pendOwner = 1;
            pendWrite = 1'b0;
            pendData  = refMem[fb_address[14:0]];
            streak    = cs ? ((streak < 3) ? streak + 1 : 3) : 0;
        end
        countdown = 3;
    endtask

    task automatic doReset();
        reset = 1'b1;
        #1;
        pendOwner = 0;
        lastFb    = 16'h0000;
        lastCpu   = 16'h0000;
        streak    = 0;
        stepCycle();
        checkOutput("rst_ram_addr", {17'b0, ram_addr}, 32'h0);
        checkOutput("rst_ram_wr_en", {31'b0, ram_wr_en}, 32'h0);
        checkOutput("rst_ram_be", {30'b0, ram_be}, 32'h0);
        checkOutput("rst_ram_wdata", {16'b0, ram_wdata}, 32'h0);
        stepCycle();
        reset = 1'b0;
    endtask

    // Run until the given owner (1=VGA, 2=CPU) is acked; requesters drop on their ack.
    task automatic waitAck(input int who, input int maxCycles, output int cycles);
        cycles = 0;
        forever begin
            stepCycle();
            cycles++;
            if (vgaAckSeen) fb_access = 1'b0;
            if (cpuAckSeen) cs = 1'b0;
            modelGrant();
            if ((who == 1 && vgaAckSeen) || (who == 2 && cpuAckSeen)) return;
            if (cycles >= maxCycles) begin
                checkOutput("ack_timeout", 32'h0, 32'h1);
                return;
            end
        end
    endtask

    task automatic applyStimulus(ref int vReqs, ref int cReqs);
        if (!fb_access && $urandom_range(0, 99) < 25) begin
            fb_access  = 1'b1;
            fb_address = 16'($urandom_range(0, 63)) | (($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h0000);
            vReqs++;
        end
        if (!cs && $urandom_range(0, 99) < 30) begin
            cs             = 1'b1;
            data_m_addr    = 15'($urandom_range(0, 63));
            data_m_wr_en   = 1'($urandom_range(0, 1));
            data_m_bytesel = 2'($urandom_range(0, 3));
            data_m_data_in = 16'($urandom);
            cReqs++;
        end
    endtask

    initial begin
        int c;
        int vIdx;
        int cpuAt;
        int fbAcks;
        int vReqs;
        int cReqs;
        int vAcks;
        int cAcks;
        logic [31:0] expCpuAt;

        for (int i = 0; i < FB_WORDS; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            mem[i]    = v;
            refMem[i] = v;
        end
        mem[16'h0010] = 16'hFFFF;  refMem[16'h0010] = 16'hFFFF;
        mem[16'h0100] = 16'h1111;  refMem[16'h0100] = 16'h1111;
        mem[16'h0200] = 16'h2222;  refMem[16'h0200] = 16'h2222;

        // Reset with both requesters asking: VGA first, three cycles later.
        fb_access    = 1'b1;
        fb_address   = 16'h0003;
        cs           = 1'b1;
        data_m_addr  = 15'h0005;
        data_m_wr_en = 1'b0;
        doReset();
        modelGrant();
        waitAck(1, 10, c);
        checkOutput("vga_first_latency", c, 3);
        waitAck(2, 10, c);
        checkOutput("cpu_second_latency", c, 3);

        // Partial-byte write then read back.
        cs             = 1'b1;
        data_m_addr    = 15'h0010;
        data_m_wr_en   = 1'b1;
        data_m_bytesel = 2'b01;
        data_m_data_in = 16'hA55A;
        modelGrant();
        waitAck(2, 10, c);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            modelGrant();
        end
        cs           = 1'b1;
        data_m_wr_en = 1'b0;
        modelGrant();
        waitAck(2, 10, c);
        checkOutput("cpu_read_0x0010", {16'b0, data_m_data_out}, 32'hFF5A);

        // Continuous VGA stream with the CPU waiting.
        fb_access   = 1'b1;
        fb_address  = 16'h0000;
        cs          = 1'b1;
        data_m_addr = 15'h0020;
        data_m_wr_en = 1'b0;
        modelGrant();
        vIdx  = 0;
        cpuAt = -1;
        for (int i = 0; i < 80; i++) begin
            stepCycle();
            if (vgaAckSeen) begin
                vIdx++;
                if (vIdx < 8) fb_address = 16'(vIdx);
                else fb_access = 1'b0;
            end
            if (cpuAckSeen) begin
                cpuAt = vIdx;
                cs = 1'b0;
            end
            modelGrant();
            if (!fb_access && !cs && pendOwner == 0) break;
        end
`ifdef VGA_FB_FAIRNESS_EN
        expCpuAt = 32'd3;
`else
        expCpuAt = 32'd8;
`endif
        checkOutput("cpu_after_vga_acks", cpuAt, expCpuAt);
        fb_access = 1'b0;
        cs        = 1'b0;

        // Request changed on the ack: the new address is fetched, the old one never again.
        fb_access  = 1'b1;
        fb_address = 16'h0100;
        modelGrant();
        c = 0;
        while (!vgaAckSeen || c == 0) begin
            stepCycle();
            c++;
            if (vgaAckSeen) fb_address = 16'h0200;
            modelGrant();
            if (c > 10) begin
                checkOutput("reissue_timeout1", 32'h0, 32'h1);
                break;
            end
        end
        checkOutput("first_fetch_0x0100", {16'b0, fb_data}, 32'h1111);
        waitAck(1, 10, c);
        checkOutput("reissued_fetch_0x0200", {16'b0, fb_data}, 32'h2222);
        fbAcks = 0;
        for (int i = 0; i < 6; i++) begin
            stepCycle();
            if (vgaAckSeen) fbAcks++;
            modelGrant();
        end
        checkOutput("no_repeat_fetch", fbAcks, 0);

        // Reset while a write sits in SERVE; write data equals the current word so either outcome is fine.
        cs             = 1'b1;
        data_m_addr    = 15'h0040;
        data_m_wr_en   = 1'b1;
        data_m_bytesel = 2'b11;
        data_m_data_in = refMem[15'h0040];
        modelGrant();
        stepCycle();
        reset = 1'b1;
        #1;
        checkOutput("serve_rst_wr_en", {31'b0, ram_wr_en}, 32'h0);
        checkOutput("serve_rst_fb_ack", {31'b0, fb_ack}, 32'h0);
        cs = 1'b0;
        doReset();
        fb_access  = 1'b1;
        fb_address = 16'h0200;
        modelGrant();
        waitAck(1, 10, c);
        checkOutput("post_reset_latency", c, 3);
        checkOutput("post_reset_fetch", {16'b0, fb_data}, 32'h2222);

        // Random interleaving of both requesters.
        vReqs = 0;
        cReqs = 0;
        vAcks = 0;
        cAcks = 0;
        for (int i = 0; i < 10000; i++) begin
            stepCycle();
            if (vgaAckSeen) begin
                vAcks++;
                fb_access = 1'b0;
            end
            if (cpuAckSeen) begin
                cAcks++;
                cs = 1'b0;
            end
            applyStimulus(vReqs, cReqs);
            modelGrant();
        end
        for (int i = 0; i < 40; i++) begin
            if (!fb_access && !cs && pendOwner == 0) break;
            stepCycle();
            if (vgaAckSeen) begin
                vAcks++;
                fb_access = 1'b0;
            end
            if (cpuAckSeen) begin
                cAcks++;
                cs = 1'b0;
            end
            modelGrant();
        end
        checkOutput("drain_done", {31'b0, (fb_access || cs)}, 32'h0);
        checkOutput("vga_acks_per_request", vAcks, vReqs);
        checkOutput("cpu_acks_per_request", cAcks, cReqs);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
